// File: rtl/fetch_pc_unit.sv
// Fetch stage: program counter, single-outstanding imem request channel, one-entry
// instruction buffer and JAL/JALR redirect. Define MISALIGN_TRAP_EN to trap on bit-1 targets.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_code,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        jump_valid,
  input  logic [31:0] jump_pc,
  input  logic [1:0]  jump_control,
  input  logic [20:0] imm,
  input  logic [31:0] rs1_data,
  output logic [31:0] link_addr,
  output logic        redirect,
  output logic        misalign_trap,
  output logic [31:0] trap_addr
);

  localparam logic [1:0] JMP_NOP = 2'b00;
  localparam logic [1:0] JAL     = 2'b01;
  localparam logic [1:0] JALR    = 2'b10;

  localparam logic [1:0] S_FETCH   = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        bv_q, bv_d;
  logic [31:0] code_q, code_d;
  logic [31:0] ipc_q, ipc_d;

  logic        is_jalr, taken, apply, trap_hit, acc;
  logic [31:0] tgt_raw, tgt_al;

  always_comb begin
    is_jalr = 1'b0;
    taken   = 1'b0;
    case (jump_control)
      JAL:     taken = jump_valid;
      JALR:    begin taken = jump_valid; is_jalr = 1'b1; end
      JMP_NOP: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

  assign tgt_raw   = is_jalr ? ((rs1_data + {{20{imm[11]}}, imm[11:0]}) & 32'hFFFF_FFFE)
                             : (jump_pc + {{11{imm[20]}}, imm});
  assign tgt_al    = tgt_raw & ~32'h3;
  assign link_addr = jump_pc + 32'd4;

`ifdef MISALIGN_TRAP_EN
  assign trap_hit = taken & tgt_raw[1];
  assign apply    = taken & ~tgt_raw[1];

  logic        trap_q;
  logic [31:0] taddr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_q  <= 1'b0;
      taddr_q <= 32'h0;
    end else begin
      trap_q <= trap_hit;
      if (trap_hit) taddr_q <= tgt_raw;
    end
  end
  assign misalign_trap = trap_q;
  assign trap_addr     = taddr_q;
`else
  assign trap_hit      = 1'b0;
  assign apply         = taken & ~trap_hit;
  assign misalign_trap = 1'b0;
  assign trap_addr     = 32'h0;
`endif

  assign redirect       = apply;
  assign imem_req_valid = (state_q == S_FETCH) & ~bv_q;
  assign imem_req_addr  = pc_q;
  assign acc            = imem_req_valid & imem_req_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bv_d    = bv_q;
    code_d  = code_q;
    ipc_d   = ipc_q;
    if (bv_q && inst_ready) bv_d = 1'b0;
    case (state_q)
      S_FETCH: if (acc) state_d = S_WAIT;
      S_WAIT: if (imem_rsp_valid) begin
        bv_d    = 1'b1;
        code_d  = imem_rsp_data;
        ipc_d   = pc_q;
        pc_d    = pc_q + 32'd4;
        state_d = S_FETCH;
      end
      S_DISCARD: if (imem_rsp_valid) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
    // A redirect overrides the sequential update; any response still owed goes through DISCARD.
    if (apply) begin
      pc_d = tgt_al;
      bv_d = 1'b0;
      case (state_q)
        S_FETCH:   state_d = acc ? S_DISCARD : S_FETCH;
        S_WAIT:    state_d = imem_rsp_valid ? S_FETCH : S_DISCARD;
        S_DISCARD: state_d = imem_rsp_valid ? S_FETCH : S_DISCARD;
        default:   state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      bv_q    <= 1'b0;
      code_q  <= 32'h0;
      ipc_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bv_q    <= bv_d;
      code_q  <= code_d;
      ipc_q   <= ipc_d;
    end
  end

  assign inst_valid = bv_q;
  assign inst_code  = code_q;
  assign inst_pc    = ipc_q;

endmodule
